// File: rtl/start_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : start_sequencer
// Description : Releases N_STAGES downstream initializers one after another.
//               Each stage waits a per-stage pre-start delay, emits a single
//               cycle start pulse, then (optionally) waits for its done level
//               before the next stage is considered. An optional done-wait
//               timeout parks the sequencer in a fault state that records
//               the offending stage.
// Ports       :
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   run (1) / pause (0) for the delay and done-wait phases
//   restart      in   synchronous return to IDLE, highest priority
//   done         in   [N_STAGES] per-stage completion level
//   start        out  [N_STAGES] registered one-cycle start pulse per stage
//   started      out  [N_STAGES] sticky record of issued start pulses
//   busy         out  sequencing in progress (delay or done-wait)
//   all_done     out  every stage has completed
//   error        out  a stage timed out waiting for done
//   error_stage  out  [STAGE_W] index of the stage that timed out
// Revision    : 1.0 - initial release
// ============================================================================
module start_sequencer #(
    parameter int                       N_STAGES  = 4,
    parameter int                       CW        = 32,
    parameter int                       STAGE_W   = 2,
    parameter logic [N_STAGES*CW-1:0]   DELAY     = {N_STAGES{CW'(1000)}},
    parameter logic [N_STAGES-1:0]      DONE_MASK = {N_STAGES{1'b1}},
    parameter logic [CW-1:0]            TIMEOUT   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [N_STAGES-1:0]   done,
    output logic [N_STAGES-1:0]   start,
    output logic [N_STAGES-1:0]   started,
    output logic                  busy,
    output logic                  all_done,
    output logic                  error,
    output logic [STAGE_W-1:0]    error_stage
);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_wait_delay = 3'd1;
    localparam logic [2:0] c_st_wait_done  = 3'd2;
    localparam logic [2:0] c_st_complete   = 3'd3;
    localparam logic [2:0] c_st_fault      = 3'd4;

    localparam logic [STAGE_W-1:0] c_last_stage = STAGE_W'(N_STAGES - 1);
    localparam logic [CW-1:0]      c_cnt_max    = '1;

    logic [2:0]            r_state;
    logic [STAGE_W-1:0]    r_stage;
    logic [CW-1:0]         r_cnt;
    logic [N_STAGES-1:0]   r_start;
    logic [N_STAGES-1:0]   r_started;
    logic [STAGE_W-1:0]    r_error_stage;

    // Per-stage selections for the current stage index. Done with an explicit
    // compare loop so an index value beyond N_STAGES selects nothing.
    logic [CW-1:0]         w_delay_k;
    logic                  w_done_k;
    logic                  w_mask_k;
    logic [N_STAGES-1:0]   w_stage_onehot;
    logic                  w_stage_ok;
    logic                  w_timeout_hit;

    always_comb begin
        w_delay_k      = '0;
        w_done_k       = 1'b0;
        w_mask_k       = 1'b0;
        w_stage_onehot = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (r_stage == STAGE_W'(i)) begin
                w_delay_k         = DELAY[i*CW +: CW];
                w_done_k          = done[i];
                w_mask_k          = DONE_MASK[i];
                w_stage_onehot[i] = 1'b1;
            end
        end
    end

    // A stage whose done is masked off needs no acknowledgement at all.
    assign w_stage_ok    = !w_mask_k || w_done_k;
    // The count starts at 0 on entry, so TIMEOUT-1 is reached on the
    // TIMEOUT-th active cycle spent waiting.
    assign w_timeout_hit = (TIMEOUT != '0) && (r_cnt == (TIMEOUT - CW'(1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_stage       <= '0;
            r_cnt         <= '0;
            r_start       <= '0;
            r_started     <= '0;
            r_error_stage <= '0;
        end else begin
            // start is a pulse: it only survives the cycle it is set in.
            r_start <= '0;
            if (restart) begin
                r_state       <= c_st_idle;
                r_stage       <= '0;
                r_cnt         <= '0;
                r_started     <= '0;
                r_error_stage <= '0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (enable) begin
                            r_state <= c_st_wait_delay;
                            r_stage <= '0;
                            r_cnt   <= '0;
                        end
                    end
                    c_st_wait_delay: begin
                        if (enable) begin
                            if (r_cnt == w_delay_k) begin
                                r_start   <= w_stage_onehot;
                                r_started <= r_started | w_stage_onehot;
                                r_cnt     <= '0;
                                r_state   <= c_st_wait_done;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    c_st_wait_done: begin
                        if (enable) begin
                            // done is tested before the timeout so a
                            // simultaneous arrival is never a fault.
                            if (w_stage_ok) begin
                                r_cnt <= '0;
                                if (r_stage == c_last_stage) begin
                                    r_state <= c_st_complete;
                                end else begin
                                    r_stage <= r_stage + STAGE_W'(1);
                                    r_state <= c_st_wait_delay;
                                end
                            end else if (w_timeout_hit) begin
                                r_state       <= c_st_fault;
                                r_error_stage <= r_stage;
                            end else if (r_cnt != c_cnt_max) begin
                                // Saturate when the timeout is disabled so
                                // an endless wait never wraps the count.
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    c_st_complete: r_state <= c_st_complete;
                    c_st_fault:    r_state <= c_st_fault;
                    default: begin
                        r_state <= c_st_idle;
                        r_stage <= '0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign start       = r_start;
    assign started     = r_started;
    assign busy        = (r_state == c_st_wait_delay) || (r_state == c_st_wait_done);
    assign all_done    = (r_state == c_st_complete);
    assign error       = (r_state == c_st_fault);
    assign error_stage = r_error_stage;

endmodule
`default_nettype wire

// File: tb/tb_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_start_sequencer
// Description : Self-checking bench for start_sequencer. Three instances with
//               different configurations share the same stimulus:
//                 dut 0 : D={4,2,0}, all stages need done, no timeout
//                 dut 1 : D={4,2,0}, all stages need done, timeout 8
//                 dut 2 : D={4,2,0}, only stage 1 needs done, no timeout
//               Directed scenarios use cycle numbers taken from the
//               behaviour description; the random scenario compares every
//               instance against a behavioural model each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_start_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] done = 3'b000;

    logic [2:0] d_start   [3];
    logic [2:0] d_started [3];
    logic       d_busy    [3];
    logic       d_all     [3];
    logic       d_err     [3];
    logic [1:0] d_errst   [3];

    int n_checks = 0;
    int n_pass   = 0;

    initial forever #5 clock = ~clock;

    start_sequencer #(
        .N_STAGES(3), .CW(8), .STAGE_W(2),
        .DELAY({8'd0, 8'd2, 8'd4}), .DONE_MASK(3'b111), .TIMEOUT(8'd0)
    ) u_dut0 (
        .clock(clock), .reset(reset), .enable(enable), .restart(restart), .done(done),
        .start(d_start[0]), .started(d_started[0]), .busy(d_busy[0]),
        .all_done(d_all[0]), .error(d_err[0]), .error_stage(d_errst[0])
    );

    start_sequencer #(
        .N_STAGES(3), .CW(8), .STAGE_W(2),
        .DELAY({8'd0, 8'd2, 8'd4}), .DONE_MASK(3'b111), .TIMEOUT(8'd8)
    ) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .restart(restart), .done(done),
        .start(d_start[1]), .started(d_started[1]), .busy(d_busy[1]),
        .all_done(d_all[1]), .error(d_err[1]), .error_stage(d_errst[1])
    );

    start_sequencer #(
        .N_STAGES(3), .CW(8), .STAGE_W(2),
        .DELAY({8'd0, 8'd2, 8'd4}), .DONE_MASK(3'b010), .TIMEOUT(8'd0)
    ) u_dut2 (
        .clock(clock), .reset(reset), .enable(enable), .restart(restart), .done(done),
        .start(d_start[2]), .started(d_started[2]), .busy(d_busy[2]),
        .all_done(d_all[2]), .error(d_err[2]), .error_stage(d_errst[2])
    );

    // ------------------------------------------------------------------
    // Behavioural model. Phase: 0 idle, 1 delaying, 2 waiting for done,
    // 3 finished, 4 faulted. m_act counts enabled cycles spent in the
    // current phase (1-based): a start fires on enabled cycle D+1, a
    // fault on enabled waiting cycle TIMEOUT.
    // ------------------------------------------------------------------
    int         m_dly  [3][3] = '{'{4, 2, 0}, '{4, 2, 0}, '{4, 2, 0}};
    logic [2:0] m_mask [3]    = '{3'b111, 3'b111, 3'b010};
    int         m_to   [3]    = '{0, 8, 0};

    int         m_ph      [3];
    int         m_stg     [3];
    int         m_act     [3];
    logic [2:0] m_start   [3];
    logic [2:0] m_started [3];
    logic [1:0] m_errst   [3];

    always @(posedge clock or posedge reset) begin
        for (int j = 0; j < 3; j++) begin
            if (reset) begin
                m_ph[j] = 0; m_stg[j] = 0; m_act[j] = 0;
                m_start[j] = 3'b000; m_started[j] = 3'b000; m_errst[j] = 2'd0;
            end else begin
                m_start[j] = 3'b000;
                if (restart) begin
                    m_ph[j] = 0; m_stg[j] = 0; m_act[j] = 0;
                    m_started[j] = 3'b000; m_errst[j] = 2'd0;
                end else if (enable) begin
                    if (m_ph[j] == 0) begin
                        m_ph[j] = 1; m_stg[j] = 0; m_act[j] = 0;
                    end else if (m_ph[j] == 1) begin
                        m_act[j] = m_act[j] + 1;
                        if (m_act[j] == m_dly[j][m_stg[j]] + 1) begin
                            m_start[j][m_stg[j]]   = 1'b1;
                            m_started[j][m_stg[j]] = 1'b1;
                            m_ph[j] = 2; m_act[j] = 0;
                        end
                    end else if (m_ph[j] == 2) begin
                        m_act[j] = m_act[j] + 1;
                        if (!m_mask[j][m_stg[j]] || done[m_stg[j]]) begin
                            m_act[j] = 0;
                            if (m_stg[j] == 2) m_ph[j] = 3;
                            else begin m_stg[j] = m_stg[j] + 1; m_ph[j] = 1; end
                        end else if (m_to[j] != 0 && m_act[j] == m_to[j]) begin
                            m_ph[j] = 4;
                            m_errst[j] = 2'(m_stg[j]);
                        end
                    end
                end
            end
        end
    end

    // Advance one clock and settle just after the edge.
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle;
        enable  = 1'b0;
        done    = 3'b000;
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if ({d_start[j], d_started[j], d_busy[j], d_all[j], d_err[j], d_errst[j]} !== 11'd0) begin
                $display("FAIL reset_outputs dut%0d got=%b exp=0", j,
                         {d_start[j], d_started[j], d_busy[j], d_all[j], d_err[j], d_errst[j]});
            end else n_pass++;
        end
        step();
        #3 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if ({d_busy[0], d_start[0]} !== 4'd0) begin
                $display("FAIL idle_after_reset cycle%0d got=%b exp=0000", c, {d_busy[0], d_start[0]});
            end else n_pass++;
        end
    endtask

    task automatic test_basic;
        logic [2:0] exp_start;
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step();
            exp_start = (c == 6) ? 3'b001 : (c == 14) ? 3'b010 : (c == 16) ? 3'b100 : 3'b000;
            n_checks++;
            if (d_start[0] !== exp_start) begin
                $display("FAIL basic_start cycle%0d got=%b exp=%b", c, d_start[0], exp_start);
            end else n_pass++;
            if (c == 10) done = 3'b001;
            if (c == 14) done = 3'b011;
            if (c == 17) done = 3'b111;
        end
        n_checks++;
        if ({d_all[0], d_busy[0], d_started[0]} !== 5'b10111) begin
            $display("FAIL basic_complete got=%b exp=10111", {d_all[0], d_busy[0], d_started[0]});
        end else n_pass++;
    endtask

    task automatic test_timeout;
        logic [2:0] exp_start;
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            exp_start = (c == 6) ? 3'b001 : (c == 10) ? 3'b010 : 3'b000;
            n_checks++;
            if ({d_start[1], d_err[1], d_busy[1]} !== {exp_start, (c >= 18), (c < 18)}) begin
                $display("FAIL timeout_seq cycle%0d got=%b exp=%b", c,
                         {d_start[1], d_err[1], d_busy[1]}, {exp_start, (c >= 18), (c < 18)});
            end else n_pass++;
            if (c == 18) begin
                n_checks++;
                if (d_errst[1] !== 2'd1) begin
                    $display("FAIL timeout_stage got=%0d exp=1", d_errst[1]);
                end else n_pass++;
            end
            if (c == 6) done = 3'b001;
            if (c == 7) done = 3'b000;
        end
        restart = 1'b1;
        enable  = 1'b0;
        step();
        restart = 1'b0;
        n_checks++;
        if ({d_start[1], d_started[1], d_busy[1], d_all[1], d_err[1], d_errst[1]} !== 11'd0) begin
            $display("FAIL timeout_restart got=%b exp=0",
                     {d_start[1], d_started[1], d_busy[1], d_all[1], d_err[1], d_errst[1]});
        end else n_pass++;
    endtask

    task automatic test_tie;
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            n_checks++;
            if (d_err[1] !== 1'b0) begin
                $display("FAIL tie_no_fault cycle%0d got=%b exp=0", c, d_err[1]);
            end else n_pass++;
            if (c == 19) begin
                n_checks++;
                if (d_start[1] !== 3'b100) begin
                    $display("FAIL tie_advance got=%b exp=100", d_start[1]);
                end else n_pass++;
            end
            if (c == 6)  done = 3'b001;
            if (c == 7)  done = 3'b000;
            if (c == 17) done = 3'b010;
        end
    endtask

    task automatic test_restart_on_start;
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            n_checks++;
            if (d_start[0] !== ((c == 12) ? 3'b001 : 3'b000)) begin
                $display("FAIL restart_start cycle%0d got=%b exp=%b", c, d_start[0],
                         (c == 12) ? 3'b001 : 3'b000);
            end else n_pass++;
            if (c == 6) begin
                n_checks++;
                if ({d_busy[0], d_started[0]} !== 4'b0000) begin
                    $display("FAIL restart_idle got=%b exp=0000", {d_busy[0], d_started[0]});
                end else n_pass++;
            end
            if (c == 5) restart = 1'b1;
            if (c == 6) restart = 1'b0;
        end
    endtask

    task automatic test_pause_masked;
        logic [2:0] exp_start;
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            step();
            exp_start = (c == 11) ? 3'b001 : (c == 15) ? 3'b010 : (c == 18) ? 3'b100 : 3'b000;
            n_checks++;
            if (d_start[2] !== exp_start) begin
                $display("FAIL pause_start cycle%0d got=%b exp=%b", c, d_start[2], exp_start);
            end else n_pass++;
            if (c == 2) enable = 1'b0;
            if (c == 7) enable = 1'b1;
            if (c == 16) done = 3'b010;
            if (c == 17) done = 3'b000;
        end
        n_checks++;
        if ({d_all[2], d_started[2]} !== 4'b1111) begin
            $display("FAIL masked_complete got=%b exp=1111", {d_all[2], d_started[2]});
        end else n_pass++;
    endtask

    task automatic test_async_reset;
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 8; c++) step();
        n_checks++;
        if ({d_busy[1], d_started[1]} !== 4'b1001) begin
            $display("FAIL areset_pre got=%b exp=1001", {d_busy[1], d_started[1]});
        end else n_pass++;
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({d_start[1], d_started[1], d_busy[1], d_all[1], d_err[1], d_errst[1]} !== 11'd0) begin
            $display("FAIL areset_mid_cycle got=%b exp=0",
                     {d_start[1], d_started[1], d_busy[1], d_all[1], d_err[1], d_errst[1]});
        end else n_pass++;
        enable = 1'b0;
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({d_busy[1], d_start[1]} !== 4'd0) begin
                $display("FAIL areset_hold cycle%0d got=%b exp=0000", c, {d_busy[1], d_start[1]});
            end else n_pass++;
        end
        enable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            n_checks++;
            if ({d_busy[1], d_start[1]} !== {1'b1, (c == 6) ? 3'b001 : 3'b000}) begin
                $display("FAIL areset_rerun cycle%0d got=%b exp=%b", c, {d_busy[1], d_start[1]},
                         {1'b1, (c == 6) ? 3'b001 : 3'b000});
            end else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [10:0] exp_v;
        logic [10:0] got_v;
        go_idle();
        for (int c = 0; c < 800; c++) begin
            enable  = ($urandom_range(0, 99) < 80);
            restart = ($urandom_range(0, 99) < 3);
            for (int b = 0; b < 3; b++) done[b] = ($urandom_range(0, 99) < 20);
            step();
            for (int j = 0; j < 3; j++) begin
                exp_v = {m_start[j], m_started[j], (m_ph[j] == 1 || m_ph[j] == 2),
                         (m_ph[j] == 3), (m_ph[j] == 4), m_errst[j]};
                got_v = {d_start[j], d_started[j], d_busy[j], d_all[j], d_err[j], d_errst[j]};
                n_checks++;
                if (got_v !== exp_v) begin
                    $display("FAIL random dut%0d cycle%0d got=%b exp=%b", j, c, got_v, exp_v);
                end else n_pass++;
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_tie();
        test_restart_on_start();
        test_pause_masked();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 Parameter N_STAGES, default 4: number of sequenced start channels, range 1..16.
REQ-002 Parameter CW, default 32: width of the delay and timeout counters.
REQ-003 Parameter STAGE_W, default 2: width of error_stage; the SHALL satisfy 2**STAGE_W >= N_STAGES.
REQ-004 Parameter DELAY, default {4{32'd1000}}: N_STAGES*CW packed vector; slice k holds the pre-start delay D_k for stage k.
REQ-005 Parameter DONE_MASK, default all ones: N_STAGES bits; bit k set means stage k waits for done[k].
REQ-006 Parameter TIMEOUT, default 32'd0: CW-bit done-wait limit in cycles; 0 disables the timeout.
REQ-007 clock  input  1  single system clock; all logic is on the rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  run/pause for the sequence.
REQ-010 restart  input  1  single-cycle synchronous request to return to IDLE.
REQ-011 done  input  N_STAGES  per-stage completion level from the downstream initializer.
REQ-012 start  output  N_STAGES  registered single-cycle start pulse per stage.
REQ-013 started  output  N_STAGES  registered sticky level; bit k is high once start[k] has pulsed.
REQ-014 busy  output  1  high in WAIT_DELAY or WAIT_DONE.
REQ-015 all_done  output  1  high in COMPLETE.
REQ-016 error  output  1  high in FAULT.
REQ-017 error_stage  output  STAGE_W  index of the stage that timed out.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_DELAY, WAIT_DONE, COMPLETE and FAULT; a stage index k and a CW-bit counter cnt accompany it.
REQ-019 In IDLE with enable=1, the FSM SHALL move to WAIT_DELAY on the next edge with k=0 and cnt=0.
REQ-020 In WAIT_DELAY with enable=1, when cnt==D_k the FSM SHALL, on that edge, set start[k]=1 for exactly one cycle, set started[k]=1, clear cnt and enter WAIT_DONE.
- Otherwise cnt increments.
- start[k] is therefore high D_k+1 cycles after WAIT_DELAY entry.
REQ-021 In WAIT_DONE, when DONE_MASK[k]=0, or when done[k]=1 is sampled, the FSM SHALL advance.
- If k<N_STAGES-1: go to WAIT_DELAY with k+1 and cnt=0.
- If k=N_STAGES-1: go to COMPLETE.
REQ-022 In WAIT_DONE, with TIMEOUT!=0 and done[k]=0, the FSM SHALL enter FAULT when cnt==TIMEOUT-1, setting error_stage=k; otherwise cnt increments.
REQ-023 When done[k] is sampled high in the same cycle as the timeout condition, done SHALL win and no FAULT occurs.
REQ-024 done bits SHALL be ignored except for done[k] in WAIT_DONE; an early or stale done[k] that is still high on entry satisfies the stage immediately.
REQ-025 enable=0 SHALL freeze state, k and cnt in WAIT_DELAY and WAIT_DONE, including the timeout count.
- A start pulse already issued is not repeated or extended.
REQ-026 COMPLETE and FAULT SHALL be held until restart, independent of enable.
REQ-027 restart=1 SHALL take priority over every other condition in every state.
- Next state is IDLE.
- start, started, cnt, k, error and error_stage are cleared.
- After restart, if enable is still high, the sequence reruns from stage 0.
REQ-028 start SHALL be one-hot or zero in every cycle.
REQ-029 busy, all_done and error SHALL be decoded from registered state, and at most one of them is high in any cycle.
REQ-030 cnt comparisons SHALL be unsigned at full CW width, and cnt SHALL never wrap; the compare always terminates first.

Reset
REQ-031 When reset is asserted, the block SHALL asynchronously force IDLE with k=0, cnt=0, start=0, started=0, busy=0, all_done=0, error=0 and error_stage=0.
REQ-032 When reset is deasserted, the block SHALL remain in IDLE until enable is sampled high.
REQ-033 A reset mid-sequence SHALL abort the sequence without emitting further start pulses.

Verification
REQ-034 Basic sequence: N_STAGES=3, D={4,2,0}, DONE_MASK=3'b111, TIMEOUT=0; enable high at cycle 0 -> start[0] at cycle 6; done[0] driven high at cycle 10 -> start[1] at cycle 14; done[1] high -> start[2] 2 cycles later; done[2] high -> all_done and started=3'b111.
REQ-035 Timeout: TIMEOUT=8, done[1] held low -> FAULT exactly 8 cycles after WAIT_DONE entry, error=1, error_stage=1, start[2] never pulses; then restart -> IDLE with all outputs 0.
REQ-036 Masked stage and pause: DONE_MASK=3'b010; enable dropped for 5 cycles during the stage-0 delay -> start[0] is late by exactly 5 cycles; stage 2 advances without done.
REQ-037 Tie and restart: done[k] rising on the exact timeout cycle -> no FAULT; restart pulse in the same cycle as a start condition -> no start pulse, IDLE next cycle.
REQ-038 Async reset: reset asserted between clock edges during WAIT_DONE -> outputs are 0 before the next edge; no start pulse after release until enable is sampled high.
